// File: rtl/axi_read_initiator_pkg.sv
// Shared types and constants for the AXI4-Lite burst read initiator.
package axi_read_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam logic [1:0] RRESP_OKAY   = 2'b00;
  localparam logic [1:0] RRESP_EXOKAY = 2'b01;
  localparam logic [1:0] RRESP_SLVERR = 2'b10;
  localparam logic [1:0] RRESP_DECERR = 2'b11;

  localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/axi_read_initiator_if.sv
// Command, AXI4-Lite read (AR/R) and result channels of the read initiator.
interface axi_read_initiator_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_len;

  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [2:0]  arprot;

  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  logic        data_valid;
  logic        data_ready;
  logic [31:0] data;
  logic        data_err;
  logic        data_last;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len,
    output cmd_ready,
    output arvalid, araddr, arprot,
    input  arready,
    input  rvalid, rdata, rresp,
    output rready,
    output data_valid, data, data_err, data_last,
    input  data_ready
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len,
    input  cmd_ready,
    input  arvalid, araddr, arprot,
    output arready,
    output rvalid, rdata, rresp,
    input  rready,
    input  data_valid, data, data_err, data_last,
    output data_ready
  );

endinterface

// File: rtl/axi_rd_timeout.sv
// Counts consecutive cycles without read data and flags expiry on the TIMEOUT_CYCLES-th one.
module axi_rd_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic count,
  input  logic clear,
  output logic expire
);

  localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] cnt;

  assign expire = count && (cnt == W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count && !expire) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/axi_read_initiator.sv
// Turns (address, length) commands into single-outstanding AXI4-Lite reads, one result per beat.
// Optional read-data timeout with late-response drain: define AXI_RD_TIMEOUT_EN.
module axi_read_initiator
  import axi_read_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  axi_read_initiator_if.master bus,
  output logic                 busy
);

  state_t      state;
  state_t      next_state;
  logic [31:0] addr;
  logic [3:0]  beats_left;
  logic [31:0] data_q;
  logic        err_q;
  logic        last_q;
  logic        ready_en;
  logic        drain;
  logic        expire;

  logic cmd_hs;
  logic ar_hs;
  logic r_hs;
  logic d_hs;
  logic resp_err;

  assign cmd_hs   = bus.cmd_valid && bus.cmd_ready;
  assign ar_hs    = (state == ADDR) && bus.arready;
  assign r_hs     = (state == RESP) && bus.rvalid;
  assign d_hs     = (state == OUT) && bus.data_ready;
  assign resp_err = (bus.rresp != RRESP_OKAY);

`ifdef AXI_RD_TIMEOUT_EN
  logic to_count;
  logic to_clear;

  assign to_count = (state == RESP) && !bus.rvalid;
  assign to_clear = (state != RESP);

  axi_rd_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (aclk),
    .rst_n (aresetn),
    .count (to_count),
    .clear (to_clear),
    .expire(expire)
  );

  // A timed-out read is still owed one R beat; swallow it before taking new work.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      drain <= 1'b0;
    end else if ((state == RESP) && expire) begin
      drain <= 1'b1;
    end else if (drain && bus.rvalid) begin
      drain <= 1'b0;
    end
  end
`else
  assign expire = 1'b0;
  assign drain  = 1'b0;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (cmd_hs) next_state = ADDR;
      ADDR: if (ar_hs) next_state = RESP;
      RESP: if (bus.rvalid || expire) next_state = OUT;
      OUT:  if (d_hs) next_state = last_q ? IDLE : ADDR;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready  = (state == IDLE) && ready_en && !drain;
    bus.arvalid    = (state == ADDR);
    bus.araddr     = addr;
    bus.arprot     = 3'b000;
    bus.rready     = (state == RESP) || drain;
    bus.data_valid = (state == OUT);
    bus.data       = data_q;
    bus.data_err   = err_q;
    bus.data_last  = last_q;
    busy           = (state != IDLE) || drain;
  end

  // ready_en keeps cmd_ready low during reset and raises it on the first edge after release.
  // Adding WORD_BYTES leaves the low two address bits untouched and wraps at 2^32.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ready_en   <= 1'b0;
      addr       <= '0;
      beats_left <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (cmd_hs) begin
        addr       <= bus.cmd_addr;
        beats_left <= bus.cmd_len;
      end else if (d_hs && !last_q) begin
        addr       <= addr + WORD_BYTES;
        beats_left <= beats_left - 4'd1;
      end
      if (r_hs) begin
        data_q <= bus.rdata;
        err_q  <= resp_err;
        last_q <= resp_err || (beats_left == 4'd0);
      end else if ((state == RESP) && expire) begin
        data_q <= '0;
        err_q  <= 1'b1;
        last_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_read_initiator.sv
// Self-checking bench: directed table, randomized bursts against a per-beat model, reset and timeout sequences.
`timescale 1ns/1ps
module tb_axi_read_initiator;
  import axi_read_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  len;
    int          errBeat;
    int          arDly;
    int          rDly;
    int          dDly;
    logic [31:0] key;
    int          expBeats;
    logic [31:0] expLastAddr;
    logic [31:0] expFirstData;
  } vec_t;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  axi_read_initiator_if bus ();

  axi_read_initiator #(
    .TIMEOUT_CYCLES(16)
  ) dut (
    .aclk   (aclk),
    .aresetn(aresetn),
    .bus    (bus),
    .busy   (busy)
  );

  always #5 aclk = ~aclk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Handshake exclusivity; rready may overlap only while draining a timed-out read.
  always @(negedge aclk) begin
    if (aresetn) begin
      checkOutput("excl_cmd_ready", 64'(bus.cmd_ready && (bus.arvalid || bus.rready || bus.data_valid)), 64'd0);
      checkOutput("excl_ar_dv", 64'(bus.arvalid && bus.data_valid), 64'd0);
`ifndef AXI_RD_TIMEOUT_EN
      checkOutput("excl_rready", 64'(bus.rready && (bus.arvalid || bus.data_valid)), 64'd0);
`endif
    end
  end

  // Plays cache and result sink for one command; expected beats come from address/length/error rules.
  task automatic applyStimulus(input vec_t v, output int gotBeats, output logic [31:0] gotLast,
                               output logic [31:0] gotFirst);
    int          nExp;
    bit          ok;
    logic [31:0] a;
    logic [1:0]  resp;
    logic        expErr;
    logic        expLast;
    gotBeats = 0;
    gotLast  = '0;
    gotFirst = '0;
    nExp = (v.errBeat >= 0 && v.errBeat <= int'(v.len)) ? v.errBeat + 1 : int'(v.len) + 1;
    bus.cmd_addr  = v.addr;
    bus.cmd_len   = v.len;
    bus.cmd_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      if (bus.cmd_ready) ok = 1'b1;
      @(posedge aclk); #1;
    end
    bus.cmd_valid = 1'b0;
    if (!ok) begin
      checkOutput("cmd_accept_timeout", 64'd0, 64'd1);
      return;
    end
    for (int i = 0; i < nExp; i++) begin
      a = v.addr + 32'(4 * i);
      bus.cmd_valid = 1'($urandom % 2);
      bus.cmd_addr  = $urandom;
      checkOutput("arvalid_latency", 64'(bus.arvalid), 64'd1);
      if (!bus.arvalid) return;
      checkOutput("araddr", 64'(bus.araddr), 64'(a));
      checkOutput("arprot", 64'(bus.arprot), 64'd0);
      gotLast = bus.araddr;
      for (int k = 0; k < v.arDly; k++) begin
        @(posedge aclk); #1;
        checkOutput("ar_hold", {31'd0, bus.arvalid, bus.araddr}, {31'd0, 1'b1, a});
      end
      bus.arready = 1'b1;
      @(posedge aclk); #1;
      bus.arready = 1'b0;
      for (int k = 0; k <= v.rDly; k++) begin
        checkOutput("rready", 64'(bus.rready), 64'd1);
        if (k < v.rDly) begin
          @(posedge aclk); #1;
        end
      end
      resp = (i == v.errBeat) ? 2'($urandom_range(1, 3)) : RRESP_OKAY;
      bus.rvalid = 1'b1;
      bus.rdata  = a ^ v.key;
      bus.rresp  = resp;
      @(posedge aclk); #1;
      bus.rvalid = 1'b0;
      bus.rdata  = $urandom;
      bus.rresp  = 2'($urandom);
      expErr  = (resp != RRESP_OKAY);
      expLast = expErr || (i == int'(v.len));
      checkOutput("data_valid_latency", 64'(bus.data_valid), 64'd1);
      checkOutput("data", 64'(bus.data), 64'(a ^ v.key));
      checkOutput("data_err", 64'(bus.data_err), 64'(expErr));
      checkOutput("data_last", 64'(bus.data_last), 64'(expLast));
      if (i == 0) gotFirst = bus.data;
      gotBeats++;
      for (int k = 0; k < v.dDly; k++) begin
        @(posedge aclk); #1;
        checkOutput("data_hold", {29'd0, bus.data_valid, bus.data_err, bus.data_last, bus.data},
                    {29'd0, 1'b1, expErr, expLast, a ^ v.key});
      end
      bus.data_ready = 1'b1;
      bus.cmd_valid  = 1'b0;
      @(posedge aclk); #1;
      bus.data_ready = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      checkOutput("no_extra_arvalid", 64'(bus.arvalid), 64'd0);
      checkOutput("busy_after", 64'(busy), 64'd0);
      checkOutput("cmd_ready_after", 64'(bus.cmd_ready), 64'd1);
      @(posedge aclk); #1;
    end
  endtask

  vec_t        tbl[6];
  vec_t        rv;
  int          gotBeats;
  logic [31:0] gotLast;
  logic [31:0] gotFirst;
  int          waited;

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_addr   = '0;
    bus.cmd_len    = '0;
    bus.arready    = 1'b0;
    bus.rvalid     = 1'b0;
    bus.rdata      = '0;
    bus.rresp      = '0;
    bus.data_ready = 1'b0;

    tbl[0] = '{32'h0000_0001, 4'd0, -1, 0, 0, 0, 32'hDEAD_BEEE, 1, 32'h0000_0001, 32'hDEAD_BEEF};
    tbl[1] = '{32'h0000_0100, 4'd3, -1, 0, 0, 0, 32'h0000_0000, 4, 32'h0000_010C, 32'h0000_0100};
    tbl[2] = '{32'hFFFF_FFF8, 4'd2, -1, 1, 1, 1, 32'h0000_0000, 3, 32'h0000_0000, 32'hFFFF_FFF8};
    tbl[3] = '{32'h0000_0200, 4'd3,  1, 0, 2, 0, 32'h1111_1111, 2, 32'h0000_0204, 32'h1111_1311};
    tbl[4] = '{32'h0000_0040, 4'd1, -1, 5, 0, 3, 32'hFFFF_0000, 2, 32'h0000_0044, 32'hFFFF_0040};
    tbl[5] = '{32'h1000_0002, 4'd15, -1, 0, 0, 0, 32'h0000_0000, 16, 32'h1000_003E, 32'h1000_0002};

    repeat (2) @(posedge aclk);
    #1;
    checkOutput("rst_arvalid", 64'(bus.arvalid), 64'd0);
    checkOutput("rst_rready", 64'(bus.rready), 64'd0);
    checkOutput("rst_data_valid", 64'(bus.data_valid), 64'd0);
    checkOutput("rst_data", {30'd0, bus.data_err, bus.data_last, bus.data}, 64'd0);
    checkOutput("rst_araddr", 64'(bus.araddr), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    checkOutput("cmd_ready_after_release", 64'(bus.cmd_ready), 64'd1);

    for (int t = 0; t < 6; t++) begin
      applyStimulus(tbl[t], gotBeats, gotLast, gotFirst);
      checkOutput($sformatf("tbl%0d_beats", t), 64'(gotBeats), 64'(tbl[t].expBeats));
      checkOutput($sformatf("tbl%0d_last_addr", t), 64'(gotLast), 64'(tbl[t].expLastAddr));
      checkOutput($sformatf("tbl%0d_first_data", t), 64'(gotFirst), 64'(tbl[t].expFirstData));
    end

    for (int t = 0; t < 25; t++) begin
      rv.addr    = $urandom;
      rv.len     = 4'($urandom);
      rv.errBeat = ($urandom % 3 == 0) ? int'($urandom_range(0, 15)) : -1;
      rv.arDly   = int'($urandom_range(0, 3));
      rv.rDly    = int'($urandom_range(0, 3));
      rv.dDly    = int'($urandom_range(0, 3));
      rv.key     = $urandom;
      applyStimulus(rv, gotBeats, gotLast, gotFirst);
    end

    // Reset in the middle of a burst, while waiting for read data.
    bus.cmd_addr  = 32'h0000_0500;
    bus.cmd_len   = 4'd3;
    bus.cmd_valid = 1'b1;
    @(posedge aclk); #1;
    bus.cmd_valid = 1'b0;
    checkOutput("midrst_arvalid_before", 64'(bus.arvalid), 64'd1);
    bus.arready = 1'b1;
    @(posedge aclk); #1;
    bus.arready = 1'b0;
    checkOutput("midrst_busy_before", 64'(busy), 64'd1);
    aresetn = 1'b0;
    #1;
    checkOutput("midrst_valids", {61'd0, bus.arvalid, bus.rready, bus.data_valid}, 64'd0);
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_araddr", 64'(bus.araddr), 64'd0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    checkOutput("midrst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    rv = '{32'h0000_0600, 4'd1, -1, 0, 0, 0, 32'h0F0F_0F0F, 2, 32'h0000_0604, 32'h0F0F_090F};
    applyStimulus(rv, gotBeats, gotLast, gotFirst);
    checkOutput("post_rst_beats", 64'(gotBeats), 64'd2);
    checkOutput("post_rst_first", 64'(gotFirst), 64'h0F0F_090F);

`ifdef AXI_RD_TIMEOUT_EN
    // No read data: error beat after 16 cycles, then drain the late response.
    bus.cmd_addr  = 32'h0000_0300;
    bus.cmd_len   = 4'd0;
    bus.cmd_valid = 1'b1;
    @(posedge aclk); #1;
    bus.cmd_valid = 1'b0;
    checkOutput("to_arvalid", 64'(bus.arvalid), 64'd1);
    bus.arready = 1'b1;
    @(posedge aclk); #1;
    bus.arready = 1'b0;
    waited = 0;
    while (!bus.data_valid && waited < 40) begin
      @(posedge aclk); #1;
      waited++;
    end
    checkOutput("to_cycles", 64'(waited), 64'd16);
    checkOutput("to_beat", {30'd0, bus.data_err, bus.data_last, bus.data}, {30'd0, 2'b11, 32'd0});
    bus.data_ready = 1'b1;
    @(posedge aclk); #1;
    bus.data_ready = 1'b0;
    repeat (3) begin
      checkOutput("drain_cmd_ready", 64'(bus.cmd_ready), 64'd0);
      checkOutput("drain_rready", 64'(bus.rready), 64'd1);
      checkOutput("drain_busy", 64'(busy), 64'd1);
      @(posedge aclk); #1;
    end
    bus.rvalid = 1'b1;
    bus.rdata  = 32'hBAD0_BAD0;
    @(posedge aclk); #1;
    bus.rvalid = 1'b0;
    checkOutput("drained_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    checkOutput("drained_rready", 64'(bus.rready), 64'd0);
    checkOutput("drained_data_valid", 64'(bus.data_valid), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
